// File: rtl/fll_cfg_seq_if.sv
// FLL four-phase register port: request/write-not-read/address/data out,
// acknowledge/read data/lock back. The master side is the configuration
// sequencer and the slave side is the FLL.
interface fll_cfg_seq_if;
  logic        fll_req;
  logic        fll_wrn;
  logic [1:0]  fll_add;
  logic [31:0] fll_data;
  logic        fll_ack;
  logic [31:0] fll_r_data;
  logic        fll_lock;

  modport master (
    output fll_req,
    output fll_wrn,
    output fll_add,
    output fll_data,
    input  fll_ack,
    input  fll_r_data,
    input  fll_lock
  );

  modport slave (
    input  fll_req,
    input  fll_wrn,
    input  fll_add,
    input  fll_data,
    output fll_ack,
    output fll_r_data,
    output fll_lock
  );
endinterface

// File: rtl/fll_cfg_seq.sv
// FLL configuration sequencer: on a start pulse it writes FLL config
// register 1, reads it back to verify it, then waits for the synchronised
// lock with a programmable timeout. All port outputs are registered so that
// fll_req is glitch-free towards the FLL clock domain.
module fll_cfg_seq #(
  parameter int LOCK_CNT_W  = 16,
  parameter int LOCK_SETTLE = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  seq_start,
  input  logic [15:0]           seq_mult,
  input  logic [3:0]            seq_div,
  input  logic [LOCK_CNT_W-1:0] seq_timeout,
  output logic                  seq_busy,
  output logic                  seq_done,
  output logic [1:0]            seq_err,
  output logic [31:0]           seq_rdata,
  fll_cfg_seq_if.master         fll
);

  localparam logic [1:0]            ADDR_CFG1    = 2'b01;
  localparam logic [1:0]            ERR_OK       = 2'b00;
  localparam logic [1:0]            ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0]            ERR_MISMATCH = 2'b10;
  localparam logic [LOCK_CNT_W-1:0] SETTLE_C     = LOCK_CNT_W'(LOCK_SETTLE);
  localparam logic [LOCK_CNT_W-1:0] CNT_MAX      = {LOCK_CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_REL,
    S_RD_REQ,
    S_RD_REL,
    S_LOCK_WAIT,
    S_DONE
  } state_t;

  state_t                  state_q;
  state_t                  state_d;

  // Synchroniser stages: _p0 is the metastability catcher, _s the usable copy.
  logic                    ack_p0;
  logic                    ack_s;
  logic                    lock_p0;
  logic                    lock_s;

  logic [31:0]             cfg_q;
  logic [LOCK_CNT_W-1:0]   tmo_q;
  logic [LOCK_CNT_W-1:0]   lock_cnt_q;

  logic                    start_acc;
  logic [31:0]             cfg_in;
  logic [31:0]             cfg_sel;
  logic [1:0]              err_d;
  logic                    rd_capture;
  logic                    req_d;
  logic                    wrn_d;
  logic [1:0]              add_d;
  logic [31:0]             data_d;

  // Config word: normal mode, divider in [29:26], multiplier in [15:0].
  assign cfg_in    = {1'b1, 1'b0, seq_div, 10'b0, seq_mult};
  assign start_acc = (state_q == S_IDLE) && seq_start;
  // The write data must already carry the new word on the edge that accepts start.
  assign cfg_sel   = start_acc ? cfg_in : cfg_q;

  // Two-flop synchronisers for the FLL-domain acknowledge and the async lock.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ack_p0  <= 1'b0;
      ack_s   <= 1'b0;
      lock_p0 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      ack_p0  <= fll.fll_ack;
      ack_s   <= ack_p0;
      lock_p0 <= fll.fll_lock;
      lock_s  <= lock_p0;
    end
  end

  // Latch the request parameters once on acceptance; later input changes are ignored.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cfg_q <= '0;
      tmo_q <= '0;
    end else if (start_acc) begin
      cfg_q <= cfg_in;
      tmo_q <= seq_timeout;
    end
  end

  // FSM state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state, completion code and readback capture strobe.
  always_comb begin
    state_d    = state_q;
    err_d      = seq_err;
    rd_capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (seq_start) state_d = S_WR_REQ;
      end
      S_WR_REQ: begin
        if (ack_s) state_d = S_WR_REL;
      end
      S_WR_REL: begin
        if (!ack_s) state_d = S_RD_REQ;
      end
      S_RD_REQ: begin
        if (ack_s) begin
          rd_capture = 1'b1;
          state_d    = S_RD_REL;
        end
      end
      S_RD_REL: begin
        if (!ack_s) begin
          if (seq_rdata != cfg_q) begin
            err_d   = ERR_MISMATCH;
            state_d = S_DONE;
          end else begin
            state_d = S_LOCK_WAIT;
          end
        end
      end
      S_LOCK_WAIT: begin
        // Lock is checked first so it wins over a simultaneous timeout.
        if ((lock_cnt_q >= SETTLE_C) && lock_s) begin
          err_d   = ERR_OK;
          state_d = S_DONE;
        end else if ((tmo_q != '0) && (lock_cnt_q == tmo_q)) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Port values for the state being entered; address and data hold for the whole write+read.
  always_comb begin
    req_d  = (state_d == S_WR_REQ) || (state_d == S_RD_REQ);
    wrn_d  = (state_d != S_WR_REQ);
    add_d  = '0;
    data_d = '0;
    if ((state_d == S_WR_REQ) || (state_d == S_WR_REL) ||
        (state_d == S_RD_REQ) || (state_d == S_RD_REL)) begin
      add_d  = ADDR_CFG1;
      data_d = cfg_sel;
    end
  end

  // Registered outputs towards the FLL and the requester.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fll.fll_req  <= 1'b0;
      fll.fll_wrn  <= 1'b1;
      fll.fll_add  <= '0;
      fll.fll_data <= '0;
      seq_busy     <= 1'b0;
      seq_done     <= 1'b0;
      seq_err      <= ERR_OK;
      seq_rdata    <= '0;
    end else begin
      fll.fll_req  <= req_d;
      fll.fll_wrn  <= wrn_d;
      fll.fll_add  <= add_d;
      fll.fll_data <= data_d;
      seq_busy     <= (state_d != S_IDLE);
      seq_done     <= (state_d == S_DONE);
      seq_err      <= err_d;
      if (rd_capture) seq_rdata <= fll.fll_r_data;
    end
  end

  // Lock-wait counter: zero on entry, counts up each cycle and sticks at all-ones.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      lock_cnt_q <= '0;
    end else if ((state_d == S_LOCK_WAIT) && (state_q != S_LOCK_WAIT)) begin
      lock_cnt_q <= '0;
    end else if ((state_q == S_LOCK_WAIT) && (lock_cnt_q != CNT_MAX)) begin
      lock_cnt_q <= lock_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_fll_cfg_seq.sv
// Bench for fll_cfg_seq: behavioural FLL on the slave side, a table of
// directed cases, hand-written corner sequences and randomized runs whose
// expected result and completion cycle are computed from event timestamps.
module tb_fll_cfg_seq;
  localparam int LOCK_CNT_W  = 16;
  localparam int LOCK_SETTLE = 16;

  logic                  HCLK = 1'b0;
  logic                  HRESETn = 1'b0;
  logic                  seq_start = 1'b0;
  logic [15:0]           seq_mult = '0;
  logic [3:0]            seq_div = '0;
  logic [LOCK_CNT_W-1:0] seq_timeout = '0;
  logic                  seq_busy;
  logic                  seq_done;
  logic [1:0]            seq_err;
  logic [31:0]           seq_rdata;

  fll_cfg_seq_if fll ();

  fll_cfg_seq #(
    .LOCK_CNT_W (LOCK_CNT_W),
    .LOCK_SETTLE(LOCK_SETTLE)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .seq_start  (seq_start),
    .seq_mult   (seq_mult),
    .seq_div    (seq_div),
    .seq_timeout(seq_timeout),
    .seq_busy   (seq_busy),
    .seq_done   (seq_done),
    .seq_err    (seq_err),
    .seq_rdata  (seq_rdata),
    .fll        (fll)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural FLL ----------------
  int          m_ack_dly   = 1;
  logic [31:0] m_corrupt   = '0;
  int          m_lock_mode = 0;   // 0: lock m_lock_dly after write, 1: always high, 2: never
  int          m_lock_dly  = 40;
  int          wait_cnt    = 0;
  logic [31:0] mem         = '0;
  int          nwr = 0, nrd = 0;
  logic [31:0] wr_data = '0;
  logic [1:0]  wr_add = '0, rd_add = '0;
  int          t_wack = 0, t_rdrop = -1;
  int          viol = 0, hold = 0;
  logic [1:0]  snap_add = '0;
  logic [31:0] snap_data = '0;
  logic        req_prev = 1'b0;
  logic        last_rd = 1'b0;

  initial begin
    fll.fll_ack    = 1'b0;
    fll.fll_r_data = '0;
    fll.fll_lock   = 1'b0;
    forever begin
      @(negedge HCLK);
      if (fll.fll_req && !req_prev) begin
        snap_add  = fll.fll_add;
        snap_data = fll.fll_data;
      end else if (fll.fll_req || fll.fll_ack || hold > 0) begin
        if (fll.fll_add !== snap_add || fll.fll_data !== snap_data) viol++;
      end
      if (hold > 0) hold--;
      req_prev = fll.fll_req;
      if (fll.fll_req && !fll.fll_ack) begin
        wait_cnt++;
        if (wait_cnt >= m_ack_dly) begin
          fll.fll_ack = 1'b1;
          if (!fll.fll_wrn) begin
            mem = fll.fll_data; wr_data = fll.fll_data; wr_add = fll.fll_add;
            nwr++; t_wack = cyc; last_rd = 1'b0;
          end else begin
            fll.fll_r_data = mem ^ m_corrupt; rd_add = fll.fll_add;
            nrd++; last_rd = 1'b1;
          end
        end
      end else if (!fll.fll_req && fll.fll_ack) begin
        fll.fll_ack = 1'b0;
        hold = 2;
        if (last_rd) t_rdrop = cyc;
      end
      if (!fll.fll_req) wait_cnt = 0;
      fll.fll_lock = (m_lock_mode == 1) ||
                     (m_lock_mode == 0 && nwr > 0 && cyc >= t_wack + m_lock_dly);
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [15:0] mult;
    logic [3:0]  div;
    logic [15:0] tmo;
    int          ack_dly;
    logic [31:0] corrupt;
    int          lock_mode;
    int          lock_dly;
    logic [1:0]  exp_err;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic setup_model(input vec_t v);
    m_ack_dly = v.ack_dly; m_corrupt = v.corrupt;
    m_lock_mode = v.lock_mode; m_lock_dly = v.lock_dly;
    nwr = 0; nrd = 0; viol = 0; hold = 0; t_rdrop = -1; t_wack = 0;
    wr_data = '0; wr_add = '0; rd_add = '0;
  endtask

  task automatic run_vec(input vec_t v, input bit chk_lit);
    int          t_done, e, p_succ, p_exp;
    logic [1:0]  err_exp;
    logic [31:0] wexp;
    bit          got;
    @(negedge HCLK);
    setup_model(v);
    seq_mult = v.mult; seq_div = v.div; seq_timeout = v.tmo; seq_start = 1'b1;
    @(negedge HCLK);
    seq_start = 1'b0;
    check("req_after_start", 32'(fll.fll_req), 32'd1);
    check("busy_after_start", 32'(seq_busy), 32'd1);
    repeat (3) @(negedge HCLK);
    // start while busy, with different inputs: must have no effect
    seq_start = 1'b1; seq_mult = 16'($urandom); seq_div = 4'($urandom); seq_timeout = 16'($urandom);
    @(negedge HCLK);
    seq_start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge HCLK);
      if (seq_done) got = 1'b1;
    end
    check("done_seen", 32'(got), 32'd1);
    t_done = cyc;
    wexp = {1'b1, 1'b0, v.div, 10'b0, v.mult};
    // reference timing: ack low at negedge t_rdrop reaches the FSM 3 edges later
    e = t_rdrop + 3;
    if (v.corrupt != 0) begin
      err_exp = 2'b10; p_exp = e;
    end else begin
      p_succ = e + 1 + LOCK_SETTLE;
      if (v.lock_mode == 0 && t_wack + v.lock_dly + 3 > p_succ) p_succ = t_wack + v.lock_dly + 3;
      if (v.lock_mode == 2) p_succ = 32'h3FFF_FFFF;
      if (v.tmo != 0 && e + 1 + int'(v.tmo) < p_succ) begin
        err_exp = 2'b01; p_exp = e + 1 + int'(v.tmo);
      end else begin
        err_exp = 2'b00; p_exp = p_succ;
      end
    end
    check("err_model", 32'(seq_err), 32'(err_exp));
    check("done_cycle", 32'(t_done), 32'(p_exp));
    check("rdata_model", seq_rdata, wexp ^ v.corrupt);
    check("write_data", wr_data, wexp);
    check("write_count", 32'(nwr), 32'd1);
    check("read_count", 32'(nrd), 32'd1);
    check("write_add", 32'(wr_add), 32'd1);
    check("read_add", 32'(rd_add), 32'd1);
    check("addr_data_stable", 32'(viol), 32'd0);
    if (chk_lit) begin
      check("err_table", 32'(seq_err), 32'(v.exp_err));
      check("wdata_table", wr_data, v.exp_wdata);
      check("rdata_table", seq_rdata, v.exp_rdata);
    end
    // start during the DONE cycle is ignored
    seq_start = 1'b1;
    @(negedge HCLK);
    seq_start = 1'b0;
    check("done_one_cycle", 32'(seq_done), 32'd0);
    check("idle_busy", 32'(seq_busy), 32'd0);
    check("idle_req", 32'(fll.fll_req), 32'd0);
    check("idle_wrn", 32'(fll.fll_wrn), 32'd1);
    check("idle_add", 32'(fll.fll_add), 32'd0);
    check("idle_data", fll.fll_data, 32'd0);
    check("err_held", 32'(seq_err), 32'(err_exp));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},   32'(fll.fll_req), 32'd0);
    check({tag, "_wrn"},   32'(fll.fll_wrn), 32'd1);
    check({tag, "_add"},   32'(fll.fll_add), 32'd0);
    check({tag, "_data"},  fll.fll_data, 32'd0);
    check({tag, "_busy"},  32'(seq_busy), 32'd0);
    check({tag, "_done"},  32'(seq_done), 32'd0);
    check({tag, "_err"},   32'(seq_err), 32'd0);
    check({tag, "_rdata"}, seq_rdata, 32'd0);
  endtask

  vec_t tbl[7];
  vec_t rv;
  vec_t nom;

  initial begin
    tbl[0] = '{16'h05F5, 4'd2, 16'd1000, 1,  32'h0, 0, 40, 2'b00, 32'h8800_05F5, 32'h8800_05F5};
    tbl[1] = '{16'h05F5, 4'd2, 16'd1000, 1,  32'h1, 0, 40, 2'b10, 32'h8800_05F5, 32'h8800_05F4};
    tbl[2] = '{16'h05F5, 4'd2, 16'd100,  1,  32'h0, 2, 0,  2'b01, 32'h8800_05F5, 32'h8800_05F5};
    tbl[3] = '{16'h05F5, 4'd2, 16'd1000, 1,  32'h0, 1, 0,  2'b00, 32'h8800_05F5, 32'h8800_05F5};
    tbl[4] = '{16'hA5A5, 4'd7, 16'd2000, 50, 32'h0, 0, 30, 2'b00, 32'h9C00_A5A5, 32'h9C00_A5A5};
    tbl[5] = '{16'hFFFF, 4'hF, 16'd3,    2,  32'h0, 0, 5,  2'b01, 32'hBC00_FFFF, 32'hBC00_FFFF};
    tbl[6] = '{16'h0000, 4'h0, 16'd0,    1,  32'h0, 0, 10, 2'b00, 32'h8000_0000, 32'h8000_0000};
    nom = tbl[0];

    // reset state
    repeat (3) @(negedge HCLK);
    check_reset_vals("reset");
    HRESETn = 1'b1;
    @(negedge HCLK);

    foreach (tbl[i]) run_vec(tbl[i], 1'b1);

    // timeout 0 with lock never high: sequencer keeps waiting
    begin
      int bad;
      @(negedge HCLK);
      rv = '{16'h1234, 4'd3, 16'd0, 1, 32'h0, 2, 0, 2'b00, 32'h0, 32'h0};
      setup_model(rv);
      seq_mult = rv.mult; seq_div = rv.div; seq_timeout = '0; seq_start = 1'b1;
      @(negedge HCLK);
      seq_start = 1'b0;
      bad = 0;
      repeat (10000) begin
        @(negedge HCLK);
        if (!seq_busy || seq_done) bad++;
      end
      check("tmo0_busy_held", 32'(bad), 32'd0);
      check("tmo0_read_done", 32'(nrd), 32'd1);
      HRESETn = 1'b0;
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;
    end

    // reset in the middle of the read request
    begin
      bit found;
      @(negedge HCLK);
      rv = tbl[4];
      setup_model(rv);
      seq_mult = rv.mult; seq_div = rv.div; seq_timeout = rv.tmo; seq_start = 1'b1;
      @(negedge HCLK);
      seq_start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 1000 && !found; i++) begin
        @(negedge HCLK);
        if (fll.fll_req && fll.fll_wrn) found = 1'b1;
      end
      check("rd_req_reached", 32'(found), 32'd1);
      #1 HRESETn = 1'b0;
      #1 check_reset_vals("midreset");
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;
      run_vec(nom, 1'b1);
    end

    // randomized runs against the timing/result reference
    for (int n = 0; n < 20; n++) begin
      rv.mult      = 16'($urandom);
      rv.div       = 4'($urandom);
      rv.ack_dly   = $urandom_range(1, 6);
      rv.corrupt   = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
      rv.lock_mode = $urandom_range(0, 2);
      rv.lock_dly  = $urandom_range(1, 150);
      if (rv.lock_mode == 2 || $urandom_range(0, 3) != 0) rv.tmo = 16'($urandom_range(1, 300));
      else rv.tmo = 16'd0;
      rv.exp_err = 2'b00; rv.exp_wdata = '0; rv.exp_rdata = '0;
      run_vec(rv, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
